// File: rtl/conv_window_gen.sv
// Streaming R x C sliding-window generator: buffers R-1 image lines and emits every
// valid (unpadded, stride 1) neighbourhood as a flat bus in conv A-operand order.
module conv_window_gen #(
  parameter int In_d_W = 32,
  parameter int R      = 3,
  parameter int C      = 3,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [In_d_W-1:0]       din,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [R*C*In_d_W-1:0]   win,
  output logic                    win_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(C - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(R - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [In_d_W-1:0] line_buf [R-1][IMG_W];
  logic [In_d_W-1:0] window   [R][C];
  logic [In_d_W-1:0] new_col  [R];

  logic accept;
  logic produce;
  logic col_wrap;
  logic row_wrap;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // A presented window holds win/win_last stable until win_ready; the input side
  // stalls only while a window is waiting, so win_ready=1 streams with no bubble.
  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col == COL_LAST);
  assign row_wrap = (row == ROW_LAST);
  assign produce  = (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);

  // Incoming column: oldest buffered line on top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < R - 1; r++) begin
      new_col[r] = line_buf[r][col];
    end
    new_col[R-1] = din;
  end

  // Each line moves up one buffer; read-before-write falls out of the NBA semantics.
  always_ff @(posedge clk) begin
    if (accept && !clr) begin
      for (int r = 0; r < R - 1; r++) begin
        line_buf[r][col] <= new_col[r+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          window[r][c] <= '0;
        end
      end
    end else if (clr) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          window[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C - 1; c++) begin
          window[r][c] <= window[r][c+1];
        end
        window[r][C-1] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // An accept only happens when any pending window is being consumed, so it fully
  // decides the next window state; otherwise a consume empties the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (clr) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (accept) begin
      win_valid <= produce;
      win_last  <= produce && col_wrap && row_wrap;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        win[(r*C+c)*In_d_W +: In_d_W] = window[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 / 8-bit instance for streaming, stall,
// reset and clr cases, plus a default 8x8 / 32-bit instance for a full frame.
module tb_conv_window_gen;
  localparam int DW  = 8;
  localparam int WA  = 9 * DW + 1;
  localparam int DWB = 32;
  localparam int WB  = 9 * DWB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid_a = 1'b0;
  logic            in_ready_a;
  logic [DW-1:0]   din_a = '0;
  logic            win_valid_a;
  logic            win_ready_a = 1'b1;
  logic [9*DW-1:0] win_a;
  logic            win_last_a;

  logic             in_valid_b = 1'b0;
  logic             in_ready_b;
  logic [DWB-1:0]   din_b = '0;
  logic             win_valid_b;
  logic             win_ready_b = 1'b1;
  logic [9*DWB-1:0] win_b;
  logic             win_last_b;

  conv_window_gen #(.In_d_W(DW), .R(3), .C(3), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .din(din_a), .win_valid(win_valid_a), .win_ready(win_ready_a), .win(win_a),
    .win_last(win_last_a));

  conv_window_gen dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .din(din_b), .win_valid(win_valid_b), .win_ready(win_ready_b), .win(win_b),
    .win_last(win_last_b));

  int tests = 0;
  int fails = 0;
  logic [WA-1:0] exp_q_a[$];
  logic [WB-1:0] exp_q_b[$];
  logic [WA-1:0] exp_a;
  logic [WB-1:0] exp_b;
  int win_cnt_a  = 0;
  int last_cnt_a = 0;
  int win_cnt_b  = 0;
  int last_cnt_b = 0;
  logic [9*DWB-1:0] last_win_b = '0;
  bit rnd_en = 1'b0;

  // The four windows of a 4x4 frame of 1..16, k0..k8, computed by hand.
  logic [7:0] tab [4][9] = '{
    '{8'd1, 8'd2, 8'd3, 8'd5,  8'd6,  8'd7,  8'd9,  8'd10, 8'd11},
    '{8'd2, 8'd3, 8'd4, 8'd6,  8'd7,  8'd8,  8'd10, 8'd11, 8'd12},
    '{8'd5, 8'd6, 8'd7, 8'd9,  8'd10, 8'd11, 8'd13, 8'd14, 8'd15},
    '{8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16}};
  logic [31:0] last_tab [9] = '{32'd45, 32'd46, 32'd47, 32'd53, 32'd54, 32'd55,
                                32'd61, 32'd62, 32'd63};

  function automatic logic [9*DW-1:0] pack_a(input int n, input int base);
    logic [9*DW-1:0] v;
    for (int k = 0; k < 9; k++) v[k*DW +: DW] = tab[n][k] + DW'(base);
    return v;
  endfunction

  function automatic logic [9*DWB-1:0] pack_b(input int i, input int j);
    logic [9*DWB-1:0] v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[(r*3+c)*DWB +: DWB] = DWB'((i - 2 + r) * 8 + (j - 2 + c));
    return v;
  endfunction

  task automatic check(input string name, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitors: pop the scoreboard whenever a window is actually transferred.
  always @(negedge clk) begin
    if (rst && !clr && win_valid_a && win_ready_a) begin
      tests++;
      win_cnt_a++;
      if (win_last_a) last_cnt_a++;
      if (exp_q_a.size() == 0) begin
        fails++;
        $display("FAIL win_a_unexpected: got %0h expected none", {win_last_a, win_a});
      end else begin
        exp_a = exp_q_a.pop_front();
        if ({win_last_a, win_a} !== exp_a) begin
          fails++;
          $display("FAIL win_a: got %0h expected %0h", {win_last_a, win_a}, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && !clr && win_valid_b && win_ready_b) begin
      tests++;
      win_cnt_b++;
      if (win_last_b) begin
        last_cnt_b++;
        last_win_b = win_b;
      end
      if (exp_q_b.size() == 0) begin
        fails++;
        $display("FAIL win_b_unexpected: got %0h expected none", {win_last_b, win_b});
      end else begin
        exp_b = exp_q_b.pop_front();
        if ({win_last_b, win_b} !== exp_b) begin
          fails++;
          $display("FAIL win_b: got %0h expected %0h", {win_last_b, win_b}, exp_b);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      win_ready_a = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_a(input logic [DW-1:0] v);
    bit acc = 1'b0;
    int n = 0;
    in_valid_a = 1'b1;
    din_a = v;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_a = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_a_timeout: pixel %0d not accepted in %0d cycles", v, n);
    end
  endtask

  task automatic send_b(input logic [DWB-1:0] v);
    bit acc = 1'b0;
    int n = 0;
    in_valid_b = 1'b1;
    din_b = v;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready_b;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_b = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_b_timeout: pixel %0d not accepted in %0d cycles", v, n);
    end
  endtask

  task automatic send_frame_a(input int base, input bit gaps);
    for (int p = 0; p < 16; p++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if (p / 4 >= 2 && p % 4 >= 2)
        exp_q_a.push_back({p == 15, pack_a((p / 4 - 2) * 2 + (p % 4 - 2), base)});
      send_a(DW'(base + p + 1));
    end
  endtask

  task automatic drain_a(input string tag, input int nwin, input int nlast);
    int n = 0;
    while (exp_q_a.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    check({tag, "_windows"}, WB'(win_cnt_a), WB'(nwin));
    check({tag, "_last_count"}, WB'(last_cnt_a), WB'(nlast));
    exp_q_a.delete();
    win_cnt_a = 0;
    last_cnt_a = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset_in_ready", WB'(in_ready_a), WB'(1));
    check("reset_win_valid", WB'(win_valid_a), WB'(0));
    check("reset_win_last", WB'(win_last_a), WB'(0));
    check("reset_win", WB'(win_a), WB'(0));

    // Continuous stream, win_ready held high.
    send_frame_a(0, 1'b0);
    drain_a("s1", 4, 1);

    // Five-cycle stall right after the first window appears.
    fork
      send_frame_a(0, 1'b0);
      begin : stall
        int n;
        n = 0;
        while (!win_valid_a && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        win_ready_a = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("s2_in_ready_low", WB'(in_ready_a), WB'(0));
          check("s2_hold", WB'({win_last_a, win_a}), WB'({1'b0, pack_a(0, 0)}));
          @(posedge clk);
          #1;
        end
        win_ready_a = 1'b1;
      end
    join
    drain_a("s2", 4, 1);

    // Random input gaps and random downstream readiness.
    rnd_en = 1'b1;
    send_frame_a(0, 1'b1);
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    win_ready_a = 1'b1;
    drain_a("s3", 4, 1);

    // Back-to-back frames.
    send_frame_a(0, 1'b0);
    send_frame_a(100, 1'b0);
    drain_a("s4", 8, 2);

    // Asynchronous reset mid-frame.
    for (int p = 0; p < 9; p++) send_a(DW'(p + 1));
    #3;
    rst = 1'b0;
    #1;
    check("s5_rst_win_valid", WB'(win_valid_a), WB'(0));
    check("s5_rst_win_last", WB'(win_last_a), WB'(0));
    check("s5_rst_win", WB'(win_a), WB'(0));
    check("s5_rst_in_ready", WB'(in_ready_a), WB'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_frame_a(0, 1'b0);
    drain_a("s5_rst", 4, 1);

    // clr with a window pending and a simultaneous pixel offered.
    win_ready_a = 1'b0;
    for (int p = 0; p < 11; p++) send_a(DW'(p + 1));
    check("s5_pending_before_clr", WB'(win_valid_a), WB'(1));
    clr = 1'b1;
    win_ready_a = 1'b1;
    in_valid_a = 1'b1;
    din_a = 8'd99;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid_a = 1'b0;
    check("s5_clr_win_valid", WB'(win_valid_a), WB'(0));
    check("s5_clr_win", WB'(win_a), WB'(0));
    check("s5_clr_in_ready", WB'(in_ready_a), WB'(1));
    send_frame_a(0, 1'b0);
    drain_a("s5_clr", 4, 1);

    // Default 8x8 instance, pixels 0..63.
    for (int p = 0; p < 64; p++) begin
      if (p / 8 >= 2 && p % 8 >= 2) exp_q_b.push_back({p == 63, pack_b(p / 8, p % 8)});
      send_b(DWB'(p));
    end
    for (int n = 0; n < 200 && exp_q_b.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) begin @(posedge clk); #1; end
    check("s6_windows", WB'(win_cnt_b), WB'(36));
    check("s6_last_count", WB'(last_cnt_b), WB'(1));
    for (int k = 0; k < 9; k++)
      check("s6_last_window", WB'(last_win_b[k*DWB +: DWB]), WB'(last_tab[k]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming sliding-window generator that sits directly upstream of the conv stage. It accepts one pixel per handshake in raster order, buffers R-1 image lines, and emits each R x C neighbourhood as a flat bus packed exactly as the conv A operand expects. It applies valid (no-padding) windowing, stride 1, and supports output backpressure.

Parameters:
In_d_W, 32, pixel/data width in bits
R, 3, window rows
C, 3, window columns
IMG_W, 8, image width in pixels (>= C)
IMG_H, 8, image height in pixels (>= R)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
clr  input  1  synchronous frame abort; same effect as reset, but synchronous
in_valid  input  1  din carries a pixel
in_ready  output  1  block can accept a pixel this cycle
din  input  In_d_W  pixel, raster order (row-major, left to right)
win_valid  output  1  win holds a valid window
win_ready  input  1  downstream consumes the window this cycle
win  output  R*C*In_d_W  packed window
win_last  output  1  qualifies win: last window of the frame

Behaviour:
- Reset (rst=0, async) or clr=1 (sync): col=0, row=0, win_valid=0, win_last=0, win=0, in_ready=1. Line-buffer contents are don't-care and need no clearing.
- Pixel accept: in_valid & in_ready on a rising edge.
- in_ready = !win_valid | win_ready. This is a combinational single-stage skid, with no bubble when win_ready is held at 1.
- Storage:
  - R-1 line buffers, each IMG_W deep, addressed by col.
  - An R x C register window shifts left by one column on every accept.
  - New column: rows 0..R-2 are read from the line buffers at col (oldest line = row 0); row R-1 is din.
  - Line buffers are updated in the same cycle with read-before-write at the same address.
- Counters: col increments per accept and wraps IMG_W-1 -> 0 with row++. row wraps IMG_H-1 -> 0 at the last pixel of the frame. The next frame starts with no gap.
- Window emit: on an accept at (row>=R-1, col>=C-1), the next cycle has win_valid=1 and win = the window whose bottom-right is that pixel. win_valid is 1 cycle of latency from accept.
- Windows per frame: (IMG_H-R+1)*(IMG_W-C+1).
- Packing: element k=r*C+c occupies win[k*In_d_W +: In_d_W]. r=0 is the top (oldest) row and c=0 is the leftmost column. This matches the conv A/B element order.
- Hold: while win_valid & !win_ready, win and win_last are stable and in_ready=0.
- Consume: on win_valid & win_ready with no new window-producing accept in the same cycle, win_valid goes to 0 next cycle. Consume and a new producing accept in the same cycle load the new window, and win_valid stays 1.
- win_last=1 with the window whose bottom-right is pixel (IMG_H-1, IMG_W-1); otherwise 0.
- Accepts at col<C-1 or row<R-1 update the buffers but produce no window.
- Reset or clr mid-frame:
  - Discards the partial frame and any pending window.
  - The next accepted pixel is treated as (0,0).
  - clr has priority over a simultaneous accept.
- No arithmetic is performed. Counter widths are clog2(IMG_W) and clog2(IMG_H).

Test Plan:
1. IMG_W=4, IMG_H=4, In_d_W=8, win_ready=1, pixels 1..16, in_valid continuous:
   - Exactly 4 windows appear.
   - First window, one cycle after pixel 11 is accepted: elements k0..k8 = 1,2,3,5,6,7,9,10,11.
   - Then 2,3,4,6,7,8,10,11,12, then 5,6,7,9,10,11,13,14,15, then 6,7,8,10,11,12,14,15,16.
   - win_last=1 only with the fourth window.
2. Same stream with win_ready=0 for 5 cycles after the first window:
   - in_ready=0 and win is held at 1,2,3,5,6,7,9,10,11 throughout.
   - After release the remaining 3 windows are correct, and no pixel is lost or duplicated.
3. Random in_valid gaps of 0-3 cycles and random win_ready: the window sequence is identical to scenario 1, with 4 windows total.
4. Two back-to-back frames (values 1..16, then 101..116):
   - The second frame's first window is 101,102,103,105,106,107,109,110,111.
   - win_last is seen twice in total.
5. Assert rst=0 asynchronously after pixel 9 (and, in a separate run, pulse clr), then stream 1..16: outputs are at reset values immediately, and then exactly the scenario-1 windows follow.
6. Default parameters (8x8), pixels 0..63: 36 windows are produced, and the last window is 45,46,47,53,54,55,61,62,63 with win_last=1.
